z80_bus_tracer: RTL

//  Synthesisable Z80 bus transaction logger for the sggoc SoC. Snoops the decoded
//  z80 strobes (mem/io rd/wr, irq ack), builds one timestamped record per completed

---
 rtl/z80_bus_tracer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/z80_bus_tracer.sv
// Z80 bus transaction logger: per-strobe trackers build timestamped records that are
// filtered and buffered in a FIFO drained over valid/ready; also latches a debug io port.
module z80_bus_tracer #(
    parameter int          ADDR_W     = 16,
    parameter int          DEPTH_LOG2 = 6,
    parameter int          TS_W       = 16,
    parameter int          CNT_W      = 16,
    parameter logic [7:0]  DEBUG_PORT = 8'h01
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [15:0]                  z80_addr,
    input  logic [7:0]                   z80_di,
    input  logic [7:0]                   z80_do,
    input  logic                         z80_mem_rd,
    input  logic                         z80_mem_wr,
    input  logic                         z80_io_rd,
    input  logic                         z80_io_wr,
    input  logic                         z80_irq_rd,
    input  logic [4:0]                   type_en,
    input  logic [ADDR_W-1:0]            win_lo,
    input  logic [ADDR_W-1:0]            win_hi,
    input  logic                         clear,
    output logic [3+ADDR_W+8+TS_W-1:0]   rec_data,
    output logic                         rec_valid,
    input  logic                         rec_ready,
    output logic [DEPTH_LOG2:0]          level,
    output logic                         overflow,
    output logic [CNT_W-1:0]             drop_cnt,
    output logic [7:0]                   debug_out
);
    localparam int REC_W = 3 + ADDR_W + 8 + TS_W;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} trk_state_t;

    trk_state_t            st_q [5];
    trk_state_t            st_d [5];
    logic [ADDR_W-1:0]     snap_addr_q [5];
    logic [ADDR_W-1:0]     snap_addr_d [5];
    logic [7:0]            snap_data_q [5];
    logic [7:0]            snap_data_d [5];
    logic [4:0]            stb_s, done_s, pass_s;
    logic [TS_W-1:0]       ts_q, ts_d;
    logic [REC_W-1:0]      fifo_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  rec_valid_q, rec_valid_d;
    logic                  overflow_q, overflow_d;
    logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
    logic [7:0]            debug_q, debug_d;
    logic                  push_req_s, push_s, pop_s, fifo_drop_s;
    logic [2:0]            n_pass_s, drop_inc_s;
    logic [REC_W-1:0]      push_rec_s;
    logic [CNT_W:0]        drop_sum_s;

    function automatic logic in_window(input logic [ADDR_W-1:0] a,
                                       input logic [ADDR_W-1:0] lo,
                                       input logic [ADDR_W-1:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

    // Per-type trackers: snapshot every high cycle, complete on the falling cycle
    always_comb begin
        stb_s  = {z80_irq_rd, z80_io_wr, z80_io_rd, z80_mem_wr, z80_mem_rd};
        done_s = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            st_d[i] = st_q[i];
            case (st_q[i])
                S_IDLE: begin
                    if (stb_s[i]) st_d[i] = S_ACTIVE;
                    else          st_d[i] = S_IDLE;
                end
                S_ACTIVE: begin
                    if (stb_s[i]) begin
                        st_d[i] = S_ACTIVE;
                    end else begin
                        st_d[i]   = S_IDLE;
                        done_s[i] = 1'b1;
                    end
                end
                default: st_d[i] = S_IDLE;
            endcase
            if (stb_s[i]) begin
                snap_addr_d[i] = (i == 2 || i == 3) ? ADDR_W'(z80_addr[7:0]) : z80_addr[ADDR_W-1:0];
                snap_data_d[i] = (i == 1 || i == 3) ? z80_do : z80_di;
            end else begin
                snap_addr_d[i] = snap_addr_q[i];
                snap_data_d[i] = snap_data_q[i];
            end
        end
    end

    // Filter completions and pick the lowest type code as the record to push
    always_comb begin
        pass_s     = 5'b00000;
        n_pass_s   = 3'd0;
        push_req_s = 1'b0;
        push_rec_s = {REC_W{1'b0}};
        for (int i = 0; i < 5; i++) begin
            pass_s[i] = done_s[i] && type_en[i] &&
                        ((i >= 2) || in_window(snap_addr_q[i], win_lo, win_hi));
            n_pass_s  = n_pass_s + {2'b00, pass_s[i]};
        end
        for (int i = 4; i >= 0; i--) begin
            if (pass_s[i]) begin
                push_req_s = 1'b1;
                push_rec_s = {3'(i), snap_addr_q[i], snap_data_q[i], ts_q};
            end else begin
                push_req_s = push_req_s;
            end
        end
    end

    // FIFO control, drop accounting, timestamp and debug latch
    always_comb begin
        pop_s       = rec_valid_q && rec_ready;
        push_s      = push_req_s && ((level_q != LVL_FULL) || pop_s);
        fifo_drop_s = push_req_s && !push_s;
        // Extra same-cycle completions beyond the pushed one are lost as well.
        drop_inc_s  = n_pass_s - {2'b00, push_req_s} + {2'b00, fifo_drop_s};
        drop_sum_s  = {1'b0, drop_cnt_q} + (CNT_W+1)'(drop_inc_s);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        drop_cnt_d  = drop_cnt_q;
        if (clear) begin
            wr_ptr_d   = {DEPTH_LOG2{1'b0}};
            rd_ptr_d   = {DEPTH_LOG2{1'b0}};
            level_d    = {(DEPTH_LOG2+1){1'b0}};
            overflow_d = 1'b0;
            drop_cnt_d = {CNT_W{1'b0}};
        end else begin
            if (push_s) wr_ptr_d = wr_ptr_q + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
            else        wr_ptr_d = wr_ptr_q;
            if (pop_s)  rd_ptr_d = rd_ptr_q + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
            else        rd_ptr_d = rd_ptr_q;
            case ({push_s, pop_s})
                2'b10:   level_d = level_q + {{DEPTH_LOG2{1'b0}}, 1'b1};
                2'b01:   level_d = level_q - {{DEPTH_LOG2{1'b0}}, 1'b1};
                default: level_d = level_q;
            endcase
            if (drop_inc_s != 3'd0) begin
                overflow_d = 1'b1;
                drop_cnt_d = drop_sum_s[CNT_W] ? {CNT_W{1'b1}} : drop_sum_s[CNT_W-1:0];
            end else begin
                overflow_d = overflow_q;
                drop_cnt_d = drop_cnt_q;
            end
        end
        rec_valid_d = (level_d != {(DEPTH_LOG2+1){1'b0}});
        if (clear) ts_d = {TS_W{1'b0}};
        else       ts_d = ts_q + {{(TS_W-1){1'b0}}, 1'b1};
        if (z80_io_wr && (z80_addr[7:0] == DEBUG_PORT)) debug_d = z80_do;
        else                                            debug_d = debug_q;
    end

    // Record storage; contents need no reset since level gates visibility
    always_ff @(posedge clk) begin
        if (push_s && !clear) fifo_mem[wr_ptr_q] <= push_rec_s;
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 5; i++) begin
                st_q[i]        <= S_IDLE;
                snap_addr_q[i] <= {ADDR_W{1'b0}};
                snap_data_q[i] <= 8'h00;
            end
            ts_q        <= {TS_W{1'b0}};
            wr_ptr_q    <= {DEPTH_LOG2{1'b0}};
            rd_ptr_q    <= {DEPTH_LOG2{1'b0}};
            level_q     <= {(DEPTH_LOG2+1){1'b0}};
            rec_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= {CNT_W{1'b0}};
            debug_q     <= 8'h00;
        end else begin
            for (int i = 0; i < 5; i++) begin
                st_q[i]        <= st_d[i];
                snap_addr_q[i] <= snap_addr_d[i];
                snap_data_q[i] <= snap_data_d[i];
            end
            ts_q        <= ts_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            rec_valid_q <= rec_valid_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
            debug_q     <= debug_d;
        end
    end

    assign rec_data  = fifo_mem[rd_ptr_q];
    assign rec_valid = rec_valid_q;
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;
    assign debug_out = debug_q;

endmodule
